// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: ownership, FSM states and
// the "no write" byte-enable pattern.
package dmem_arbiter_pkg;

  typedef enum logic {
    OWNER_CPU  = 1'b0,
    OWNER_HOST = 1'b1
  } owner_e;

  typedef enum logic {
    ST_IDLE       = 1'b0,
    ST_HOST_BURST = 1'b1
  } state_e;

  localparam logic [3:0] WREN_NONE = 4'b1111;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundles the CPU port, host port and data_mem bank signals of the arbiter.
// slave = arbiter side, master = environment side (CPU, host and banks).
interface dmem_arbiter_if;

  logic        cpu_req;
  logic [3:0]  cpu_wren_n;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        host_req;
  logic        host_last;
  logic [3:0]  host_wren_n;
  logic [7:0]  host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        host_ack;

  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wren_n;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_wren_n, cpu_addr, cpu_wdata,
    input  host_req, host_last, host_wren_n, host_addr, host_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall, host_rdata, host_ack,
    output mem_addr, mem_wdata, mem_wren_n
  );

  modport master (
    output cpu_req, cpu_wren_n, cpu_addr, cpu_wdata,
    output host_req, host_last, host_wren_n, host_addr, host_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall, host_rdata, host_ack,
    input  mem_addr, mem_wdata, mem_wren_n
  );

endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module dmem_arbiter_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Clear has priority; increments stop once every bit is set.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU execute stage and a
// host/loader port. Round-robin on ties, host bursts capped at MAX_BURST beats
// while the CPU is waiting, and a saturating count of CPU stall cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstd,
  dmem_arbiter_if.slave    bus,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [7:0] LP_MAX_BURST = 8'(MAX_BURST);

  state_e     r_state;
  logic [7:0] r_beatCnt;
  owner_e     r_lastGnt;

  state_e     w_stateEff;
  logic [7:0] w_beatEff;
  owner_e     w_lastEff;
  state_e     w_stateNext;
  logic [7:0] w_beatNext;
  owner_e     w_lastNext;
  logic       w_gntCpu;
  logic       w_gntHost;
  logic       w_cpuStall;

  // While reset is asserted the grant logic already sees the reset state, so a
  // burst is abandoned in the reset cycle itself.
  assign w_stateEff = rstd ? ST_IDLE    : r_state;
  assign w_beatEff  = rstd ? 8'd0       : r_beatCnt;
  assign w_lastEff  = rstd ? OWNER_HOST : r_lastGnt;

  // Arbitration FSM register; last grant starts at HOST so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (rstd) begin
      r_state   <= ST_IDLE;
      r_beatCnt <= 8'd0;
      r_lastGnt <= OWNER_HOST;
    end else begin
      r_state   <= w_stateNext;
      r_beatCnt <= w_beatNext;
      r_lastGnt <= w_lastNext;
    end
  end

  // Grant decision and next state from the registered state and current requests.
  always_comb begin
    w_gntCpu    = 1'b0;
    w_gntHost   = 1'b0;
    w_stateNext = w_stateEff;
    w_beatNext  = w_beatEff;
    w_lastNext  = w_lastEff;

    case (w_stateEff)
      ST_IDLE: begin
        if (bus.cpu_req && bus.host_req) begin
          if (w_lastEff == OWNER_CPU) w_gntHost = 1'b1;
          else                        w_gntCpu  = 1'b1;
        end else if (bus.cpu_req) begin
          w_gntCpu = 1'b1;
        end else if (bus.host_req) begin
          w_gntHost = 1'b1;
        end
      end
      ST_HOST_BURST: begin
        if (bus.host_req && !(bus.cpu_req && (w_beatEff == LP_MAX_BURST))) begin
          w_gntHost = 1'b1;
        end else begin
          w_gntCpu    = bus.cpu_req;
          w_stateNext = ST_IDLE;
          w_beatNext  = 8'd0;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_beatNext  = 8'd0;
      end
    endcase

    if (w_gntCpu) begin
      w_lastNext = OWNER_CPU;
    end

    if (w_gntHost) begin
      w_lastNext = OWNER_HOST;
      if (bus.host_last) begin
        w_stateNext = ST_IDLE;
        w_beatNext  = 8'd0;
      end else if (w_stateEff == ST_IDLE) begin
        w_stateNext = ST_HOST_BURST;
        w_beatNext  = 8'd1;
      end else if (w_beatEff != LP_MAX_BURST) begin
        w_beatNext  = w_beatEff + 8'd1;
      end
    end
  end

  assign w_cpuStall     = bus.cpu_req & ~w_gntCpu;
  assign bus.cpu_stall  = w_cpuStall;
  assign bus.host_ack   = bus.host_req & w_gntHost;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.host_rdata = bus.mem_rdata;
  assign bus.mem_addr   = w_gntHost ? bus.host_addr  : bus.cpu_addr;
  assign bus.mem_wdata  = w_gntHost ? bus.host_wdata : bus.cpu_wdata;
  assign bus.mem_wren_n = w_gntCpu  ? bus.cpu_wren_n :
                          w_gntHost ? bus.host_wren_n : WREN_NONE;

  dmem_arbiter_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stallCnt (
    .clk     (clk),
    .i_clr   (rstd),
    .i_inc   (w_cpuStall),
    .o_count (stall_cnt)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256-word byte-lane memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        rstd;
  logic [15:0] stallCnt;
  logic [31:0] mem [256];
  int          checks;
  int          errors;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .MAX_BURST (8),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .rstd      (rstd),
    .bus       (bus),
    .stall_cnt (stallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory banks: combinational read, per-lane write on the clock edge.
  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!bus.mem_wren_n[i]) mem[bus.mem_addr][i*8 +: 8] <= bus.mem_wdata[i*8 +: 8];
    end
  end

  task automatic applyStimulus(input logic cReq, input logic [3:0] cWren, input logic [7:0] cAddr,
                               input logic [31:0] cData, input logic hReq, input logic hLast,
                               input logic [3:0] hWren, input logic [7:0] hAddr,
                               input logic [31:0] hData);
    bus.cpu_req     = cReq;
    bus.cpu_wren_n  = cWren;
    bus.cpu_addr    = cAddr;
    bus.cpu_wdata   = cData;
    bus.host_req    = hReq;
    bus.host_last   = hLast;
    bus.host_wren_n = hWren;
    bus.host_addr   = hAddr;
    bus.host_wdata  = hData;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'hF, 8'h00, 32'h0, 1'b0, 1'b0, 4'hF, 8'h00, 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rstd = 1'b1;
    idle();

    // Reset
    nextCycle();
    #2;
    checkOutput("rst_wren",  32'(bus.mem_wren_n), 32'hF);
    checkOutput("rst_stall", 32'(bus.cpu_stall),  32'h0);
    checkOutput("rst_ack",   32'(bus.host_ack),   32'h0);
    nextCycle();
    checkOutput("rst_cnt",   32'(stallCnt),       32'h0);
    rstd = 1'b0;

    // 1: CPU only write then read
    applyStimulus(1'b1, 4'h0, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, 4'hF, 8'h00, 32'h0);
    #2;
    checkOutput("t1_wr_stall", 32'(bus.cpu_stall),  32'h0);
    checkOutput("t1_wr_wren",  32'(bus.mem_wren_n), 32'h0);
    nextCycle();
    applyStimulus(1'b1, 4'hF, 8'h10, 32'h0, 1'b0, 1'b0, 4'hF, 8'h00, 32'h0);
    #2;
    checkOutput("t1_rd_data",  bus.cpu_rdata,       32'hDEADBEEF);
    checkOutput("t1_rd_stall", 32'(bus.cpu_stall),  32'h0);
    nextCycle();

    // 2: tie after reset
    rstd = 1'b1;
    idle();
    nextCycle();
    rstd = 1'b0;
    applyStimulus(1'b1, 4'hF, 8'h10, 32'h0, 1'b1, 1'b1, 4'hF, 8'h10, 32'h0);
    #2;
    checkOutput("t2_c0_stall", 32'(bus.cpu_stall), 32'h0);
    checkOutput("t2_c0_ack",   32'(bus.host_ack),  32'h0);
    checkOutput("t2_c0_cnt",   32'(stallCnt),      32'h0);
    nextCycle();
    #2;
    checkOutput("t2_c1_ack",   32'(bus.host_ack),  32'h1);
    checkOutput("t2_c1_stall", 32'(bus.cpu_stall), 32'h1);
    checkOutput("t2_c1_hdata", bus.host_rdata,     32'hDEADBEEF);
    nextCycle();
    checkOutput("t2_cnt",      32'(stallCnt),      32'h1);

    // 3: burst limit with CPU waiting
    applyStimulus(1'b1, 4'hF, 8'h10, 32'h0, 1'b1, 1'b0, 4'hF, 8'h10, 32'h0);
    #2;
    checkOutput("t3_tie_stall", 32'(bus.cpu_stall), 32'h0);
    nextCycle();
    for (int i = 0; i < 8; i++) begin
      #2;
      checkOutput($sformatf("t3_beat%0d_ack", i),   32'(bus.host_ack),  32'h1);
      checkOutput($sformatf("t3_beat%0d_stall", i), 32'(bus.cpu_stall), 32'h1);
      nextCycle();
    end
    #2;
    checkOutput("t3_rel_ack",   32'(bus.host_ack),  32'h0);
    checkOutput("t3_rel_stall", 32'(bus.cpu_stall), 32'h0);
    checkOutput("t3_rel_cnt",   32'(stallCnt),      32'd9);
    nextCycle();
    #2;
    checkOutput("t3_resume_ack", 32'(bus.host_ack), 32'h1);
    nextCycle();
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, 4'hF, 8'h00, 32'h0, 1'b1, (i == 10), 4'hF, 8'h10, 32'h0);
      #2;
      checkOutput($sformatf("t3_tail%0d_ack", i), 32'(bus.host_ack), 32'h1);
      nextCycle();
    end
    checkOutput("t3_end_cnt", 32'(stallCnt), 32'd10);

    // 4: 20-beat burst, no contention
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 4'hF, 8'h00, 32'h0, 1'b1, (i == 19), 4'h0, 8'(8'h20 + i),
                    32'hA5000000 | 32'(i));
      #2;
      checkOutput($sformatf("t4_beat%0d_ack", i), 32'(bus.host_ack), 32'h1);
      nextCycle();
    end
    applyStimulus(1'b1, 4'hF, 8'h33, 32'h0, 1'b1, 1'b1, 4'hF, 8'h20, 32'h0);
    #2;
    checkOutput("t4_idle_stall", 32'(bus.cpu_stall), 32'h0);
    checkOutput("t4_idle_ack",   32'(bus.host_ack),  32'h0);
    checkOutput("t4_rd_last",    bus.cpu_rdata,      32'hA5000013);
    nextCycle();
    #2;
    checkOutput("t4_rr_ack",     32'(bus.host_ack),  32'h1);
    checkOutput("t4_rd_first",   bus.host_rdata,     32'hA5000000);
    nextCycle();

    // 4b: unlimited burst saturates, then a CPU request releases it at once
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 4'hF, 8'h00, 32'h0, 1'b1, 1'b0, 4'hF, 8'h20, 32'h0);
      nextCycle();
    end
    applyStimulus(1'b1, 4'hF, 8'h20, 32'h0, 1'b1, 1'b0, 4'hF, 8'h20, 32'h0);
    #2;
    checkOutput("t4b_rel_stall", 32'(bus.cpu_stall), 32'h0);
    checkOutput("t4b_rel_ack",   32'(bus.host_ack),  32'h0);
    nextCycle();
    applyStimulus(1'b0, 4'hF, 8'h00, 32'h0, 1'b1, 1'b1, 4'hF, 8'h20, 32'h0);
    #2;
    checkOutput("t4b_host_ack",  32'(bus.host_ack),  32'h1);
    nextCycle();

    // 5: byte lanes
    applyStimulus(1'b0, 4'hF, 8'h00, 32'h0, 1'b1, 1'b1, 4'h0, 8'h05, 32'h11223344);
    #2;
    checkOutput("t5_host_ack", 32'(bus.host_ack), 32'h1);
    nextCycle();
    applyStimulus(1'b1, 4'hE, 8'h05, 32'h000000AA, 1'b0, 1'b0, 4'hF, 8'h00, 32'h0);
    #2;
    checkOutput("t5_cpu_wren", 32'(bus.mem_wren_n), 32'hE);
    checkOutput("t5_cpu_addr", 32'(bus.mem_addr),   32'h05);
    nextCycle();
    applyStimulus(1'b1, 4'hF, 8'h05, 32'h0, 1'b0, 1'b0, 4'hF, 8'h00, 32'h0);
    #2;
    checkOutput("t5_rd_data", bus.cpu_rdata, 32'h112233AA);
    nextCycle();

    // 6: reset in the middle of a host burst
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 4'hF, 8'h00, 32'h0, 1'b1, 1'b0, 4'h0, 8'(8'h40 + i), 32'(32'h55 + i));
      nextCycle();
    end
    rstd = 1'b1;
    applyStimulus(1'b0, 4'hF, 8'h00, 32'h0, 1'b1, 1'b0, 4'h0, 8'h42, 32'h57);
    #2;
    checkOutput("t6_rst_ack", 32'(bus.host_ack), 32'h1);
    nextCycle();
    rstd = 1'b0;
    checkOutput("t6_cnt", 32'(stallCnt), 32'h0);
    applyStimulus(1'b1, 4'hF, 8'h42, 32'h0, 1'b1, 1'b0, 4'hF, 8'h40, 32'h0);
    #2;
    checkOutput("t6_tie_stall", 32'(bus.cpu_stall), 32'h0);
    checkOutput("t6_tie_ack",   32'(bus.host_ack),  32'h0);
    checkOutput("t6_rd_data",   bus.cpu_rdata,      32'h57);
    nextCycle();
    idle();
    nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
